// File: rtl/aes_enc_iter_pkg.sv
// Shared definitions for the iterative AES-128 encryptor: FSM encoding,
// round count and the key-schedule round constants.
package aes_enc_iter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NR = 10;

    // Round constants, index 0 in the top byte.
    localparam logic [79:0] RCON_TBL = 80'h01020408102040801b36;

    // Round constant for key-schedule step i; indices beyond the table give 0.
    function automatic logic [7:0] rcon(input logic [3:0] i);
        if (i < 4'd10) begin
            return RCON_TBL[79 - 8 * int'(i) -: 8];
        end
        return 8'h00;
    endfunction

endpackage

// File: rtl/aes_enc_iter_sbox.sv
// Four parallel AES S-box lookups on a 32-bit word.
module aes_enc_iter_sbox (
    input  logic [31:0] word,
    output logic [31:0] subst
);

    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sb(input logic [7:0] b);
        return SBOX_TBL[2047 - 8 * int'(b) -: 8];
    endfunction

    // Byte-wise substitution.
    always_comb begin
        subst = {sb(word[31:24]), sb(word[23:16]), sb(word[15:8]), sb(word[7:0])};
    end

endmodule

// File: rtl/aes_enc_iter.sv
// Iterative AES-128 encryptor: one shared round datapath, one round per cycle,
// key schedule expanded on the fly alongside the state.
module aes_enc_iter
    import aes_enc_iter_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] key_in,
    input  logic [127:0] pt_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ct_out,
    output logic [127:0] key_last
);

    state_t       state, state_nxt;
    logic [127:0] state_reg, key_reg;
    logic [3:0]   rcnt;

    logic [127:0] sub_state, sr_state, mc_state, next_key, round_out;
    logic [31:0]  sub_word, temp_word;
    logic         last_round, accept;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        return {mix_col(s[127:96]), mix_col(s[95:64]), mix_col(s[63:32]), mix_col(s[31:0])};
    endfunction

    // Byte index is row + 4*column; row r is rotated left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                o[127 - 8 * (r + 4 * c) -: 8] = s[127 - 8 * (r + 4 * ((c + r) % 4)) -: 8];
            end
        end
        return o;
    endfunction

    // SubBytes on the four state columns.
    for (genvar g = 0; g < 4; g++) begin : g_sub
        aes_enc_iter_sbox u_sbox (
            .word  (state_reg[127 - 32 * g -: 32]),
            .subst (sub_state[127 - 32 * g -: 32])
        );
    end

    // SubWord(RotWord(w3)) for the key schedule.
    aes_enc_iter_sbox u_key_sbox (
        .word  ({key_reg[23:0], key_reg[31:24]}),
        .subst (sub_word)
    );

    // Round datapath: next round key and next state.
    always_comb begin
        last_round = (rcnt == 4'(NR - 1));
        temp_word  = sub_word ^ {rcon(rcnt), 24'h0};
        next_key[127:96] = key_reg[127:96] ^ temp_word;
        next_key[95:64]  = key_reg[95:64] ^ next_key[127:96];
        next_key[63:32]  = key_reg[63:32] ^ next_key[95:64];
        next_key[31:0]   = key_reg[31:0] ^ next_key[63:32];
        sr_state  = shift_rows(sub_state);
        mc_state  = mix_columns(sr_state);
        round_out = (last_round ? sr_state : mc_state) ^ next_key;
    end

    // FSM next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last_round) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Job capture, per-round update and result load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= '0;
            key_reg   <= '0;
            rcnt      <= '0;
            ct_out    <= '0;
            key_last  <= '0;
        end else if (accept) begin
            state_reg <= pt_in ^ key_in;
            key_reg   <= key_in;
            rcnt      <= '0;
        end else if (state == RUN) begin
            state_reg <= round_out;
            key_reg   <= next_key;
            if (last_round) begin
                ct_out   <= round_out;
                key_last <= next_key;
            end else begin
                rcnt <= rcnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_aes_enc_iter.sv
// Directed self-checking bench for aes_enc_iter.
module tb_aes_enc_iter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] key_in;
    logic [127:0] pt_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] ct_out;
    logic [127:0] key_last;

    int compared   = 0;
    int mismatched = 0;

    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KL1 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C2  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KL2 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    aes_enc_iter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .key_in    (key_in),
        .pt_in     (pt_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ct_out    (ct_out),
        .key_last  (key_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one job from IDLE and return just after the accept edge.
    task automatic start(input logic [127:0] k, input logic [127:0] p);
        key_in   = k;
        pt_in    = p;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Count edges until out_valid; optionally scramble inputs each cycle.
    task automatic wait_valid(input int max, input bit scramble, output int n);
        n = 0;
        for (int i = 1; i <= max; i++) begin
            tick();
            n = i;
            if (out_valid) break;
            if (scramble) begin
                key_in   = {$urandom, $urandom, $urandom, $urandom};
                pt_in    = {$urandom, $urandom, $urandom, $urandom};
                in_valid = 1'($urandom_range(0, 1));
            end
        end
        in_valid = 1'b0;
        if (!out_valid) chk("wait_timeout", 128'(out_valid), 128'd1);
    endtask

    initial begin
        int  n;
        bit  acc;
        bit  saw;
        logic [127:0] cap;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        key_in    = '0;
        pt_in     = '0;
        #1;
        chk("rst_in_ready",  128'(in_ready),  128'd1);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_ct",        ct_out,          128'd0);
        chk("rst_key_last",  key_last,        128'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("idle_in_ready", 128'(in_ready), 128'd1);

        // Scenario 1: valid stays low for 9 edges after accept, rises on the 10th
        // (the 11th edge counting the accept edge itself).
        start(K1, P1);
        chk("s1_busy", 128'(in_ready), 128'd0);
        saw = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (out_valid) saw = 1'b1;
        end
        chk("s1_early_valid", 128'(saw), 128'd0);
        tick();
        chk("s1_valid", 128'(out_valid), 128'd1);
        chk("s1_ct", ct_out, C1);
        chk("s1_key_last", key_last, KL1);

        // Scenario 3: stall in DONE with in_valid pulses and changing operands.
        saw = 1'b0;
        for (int i = 0; i < 20; i++) begin
            in_valid = i[0];
            pt_in    = {$urandom, $urandom, $urandom, $urandom};
            key_in   = {$urandom, $urandom, $urandom, $urandom};
            tick();
            if (ct_out !== C1 || key_last !== KL1 || in_ready !== 1'b0 || out_valid !== 1'b1)
                saw = 1'b1;
        end
        chk("s3_hold_stable", 128'(saw), 128'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("s3_release_idle", 128'(in_ready), 128'd1);
        chk("s3_release_nvld", 128'(out_valid), 128'd0);
        out_ready = 1'b0;

        // Scenario 2.
        start(K2, P2);
        wait_valid(20, 1'b0, n);
        chk("s2_latency", 128'(n), 128'd10);
        chk("s2_ct", ct_out, C2);
        chk("s2_key_last", key_last, KL2);
        out_ready = 1'b1;
        tick();
        chk("s2_idle", 128'(in_ready), 128'd1);

        // Scenario 4: back-to-back with in_valid held high.
        key_in   = K1;
        pt_in    = P1;
        in_valid = 1'b1;
        tick();
        key_in = K2;
        pt_in  = P2;
        n   = 0;
        cap = '0;
        for (int i = 1; i <= 30; i++) begin
            acc = in_ready && in_valid;
            tick();
            n = i;
            if (out_valid) cap = ct_out;
            if (acc) break;
        end
        chk("s4_spacing", 128'(n), 128'd12);
        chk("s4_ct1", cap, C1);
        in_valid = 1'b0;
        wait_valid(20, 1'b0, n);
        chk("s4_ct2", ct_out, C2);
        tick();
        chk("s4_idle", 128'(in_ready), 128'd1);
        out_ready = 1'b0;

        // Scenario 5: reset at rcnt=5 abandons the job.
        start(K1, P1);
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        chk("s5_rst_nvld", 128'(out_valid), 128'd0);
        chk("s5_rst_ct", ct_out, 128'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (out_valid) saw = 1'b1;
        end
        chk("s5_no_stale", 128'(saw), 128'd0);
        chk("s5_idle", 128'(in_ready), 128'd1);
        start(K2, P2);
        wait_valid(20, 1'b0, n);
        chk("s5_ct", ct_out, C2);
        chk("s5_key_last", key_last, KL2);
        out_ready = 1'b1;
        tick();

        // Scenario 6: operands scrambled every cycle during RUN.
        start(K1, P1);
        wait_valid(20, 1'b1, n);
        chk("s6_ct", ct_out, C1);
        chk("s6_key_last", key_last, KL1);
        tick();
        chk("s6_idle", 128'(in_ready), 128'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
